// File: rtl/trigger.sv
// trigger: multi-stage mask/value trigger emitting a delayed single-cycle run pulse
// Ports: clk_i/rst_in clock and async active-low reset; cmd_i/stg_i/set_*_i config writes;
//        arm_i arm/restart; data_i/stb_i strobed samples; armed_o, lvl_o, run_o status and pulse.
module trigger #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] cmd_i,
    input  logic [1:0]       stg_i,
    input  logic             set_mask_i,
    input  logic             set_val_i,
    input  logic             set_cfg_i,
    input  logic             arm_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             stb_i,
    output logic             armed_o,
    output logic [1:0]       lvl_o,
    output logic             run_o
);
    typedef enum logic [1:0] {IDLE, ARMED, DELAY} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] mask  [STAGES];
    logic [WIDTH-1:0] value [STAGES];
    logic [15:0]      dly   [STAGES];
    logic [1:0]       slvl  [STAGES];
    logic             start [STAGES];
    logic [1:0]       lvl, lvl_nx;
    logic [15:0]      cnt, cnt_nx;
    logic [STAGES-1:0] hit, hit_start;
    logic [15:0]      start_dly;
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            for (int s = 0; s < STAGES; s++) begin
                mask[s]  <= '0;
                value[s] <= '0;
                dly[s]   <= '0;
                slvl[s]  <= '0;
                start[s] <= 1'b0;
            end
        end else begin
            if (set_mask_i) mask[stg_i] <= cmd_i;
            if (set_val_i) value[stg_i] <= cmd_i;
            if (set_cfg_i) begin
                dly[stg_i]   <= cmd_i[15:0];
                slvl[stg_i]  <= cmd_i[17:16];
                start[stg_i] <= cmd_i[27];
            end
        end
    end
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        assign hit[g]       = ~|((data_i ^ value[g]) & mask[g]) && (slvl[g] <= lvl);
        assign hit_start[g] = hit[g] & start[g];
    end
    // Lowest-index start stage wins, so scan from the top down.
    always_comb begin
        start_dly = '0;
        for (int s = STAGES - 1; s >= 0; s--) if (hit_start[s]) start_dly = dly[s];
    end
    always_comb begin
        state_nx = state;
        lvl_nx   = lvl;
        cnt_nx   = cnt;
        if (arm_i) begin
            state_nx = ARMED;
            lvl_nx   = '0;
            cnt_nx   = '0;
        end else if (state == ARMED && stb_i) begin
            if (|hit_start) begin
                state_nx = DELAY;
                cnt_nx   = start_dly;
            end else if (|hit) begin
                lvl_nx = (lvl == 2'd3) ? lvl : lvl + 2'd1;
            end
        end else if (state == DELAY) begin
            if (cnt == 16'd0) state_nx = IDLE;
            else if (stb_i) cnt_nx = cnt - 16'd1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            lvl   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            lvl   <= lvl_nx;
            cnt   <= cnt_nx;
        end
    end
    // A re-arm landing on the pulse cycle cancels it.
    assign run_o   = (state == DELAY) && (cnt == 16'd0) && !arm_i;
    assign armed_o = (state != IDLE);
    assign lvl_o   = lvl;
endmodule

// File: tb/tb_trigger.sv
// tb_trigger: directed self-checking bench for the trigger unit
module tb_trigger;
    logic        clk_i = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] cmd_i = '0;
    logic [1:0]  stg_i = '0;
    logic        set_mask_i = 1'b0;
    logic        set_val_i = 1'b0;
    logic        set_cfg_i = 1'b0;
    logic        arm_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        stb_i = 1'b0;
    logic        armed_o;
    logic [1:0]  lvl_o;
    logic        run_o;
    int          checks = 0;
    int          errors = 0;
    localparam logic [31:0] ST = 32'h0800_0000;

    trigger dut (
        .clk_i(clk_i), .rst_in(rst_in), .cmd_i(cmd_i), .stg_i(stg_i),
        .set_mask_i(set_mask_i), .set_val_i(set_val_i), .set_cfg_i(set_cfg_i),
        .arm_i(arm_i), .data_i(data_i), .stb_i(stb_i),
        .armed_o(armed_o), .lvl_o(lvl_o), .run_o(run_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic run, input logic armed, input logic [1:0] lvl);
        chk({tag, ".run"}, {31'd0, run_o}, {31'd0, run});
        chk({tag, ".armed"}, {31'd0, armed_o}, {31'd0, armed});
        chk({tag, ".lvl"}, {30'd0, lvl_o}, {30'd0, lvl});
    endtask

    task automatic wr(input logic [1:0] s, input logic [31:0] mk, input logic [31:0] vl, input logic [31:0] cf);
        stg_i = s;
        cmd_i = mk; set_mask_i = 1'b1; tick(); set_mask_i = 1'b0;
        cmd_i = vl; set_val_i = 1'b1; tick(); set_val_i = 1'b0;
        cmd_i = cf; set_cfg_i = 1'b1; tick(); set_cfg_i = 1'b0;
    endtask

    // mask and value written by one command in the same cycle
    task automatic wr_mv(input logic [1:0] s, input logic [31:0] x);
        stg_i = s; cmd_i = x; set_mask_i = 1'b1; set_val_i = 1'b1;
        tick();
        set_mask_i = 1'b0; set_val_i = 1'b0;
    endtask

    task automatic cyc(input logic [31:0] d, input logic s);
        data_i = d; stb_i = s;
        tick();
        stb_i = 1'b0;
    endtask

    task automatic arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    initial begin
        tick();
        st("reset", 1'b0, 1'b0, 2'd0);
        rst_in = 1'b1;
        tick();
        st("post_reset", 1'b0, 1'b0, 2'd0);

        // single start stage, delay 0; unconfigured stages 1-3 match anything at level 0
        wr(2'd0, 32'hFF, 32'h5A, ST);
        arm();
        st("t1.arm", 1'b0, 1'b1, 2'd0);
        cyc(32'h12, 1'b1);
        st("t1.miss", 1'b0, 1'b1, 2'd1);
        cyc(32'h5A, 1'b1);
        st("t1.run", 1'b1, 1'b1, 2'd1);
        tick();
        st("t1.done", 1'b0, 1'b0, 2'd1);
        tick();
        st("t1.idle", 1'b0, 1'b0, 2'd1);

        // two-level sequence
        wr_mv(2'd2, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        wr_mv(2'd3, 32'hFFFF_FFFF);
        wr(2'd0, 32'hF, 32'h1, 32'h0);
        wr(2'd1, 32'hF, 32'h2, ST | 32'h0001_0000);
        arm();
        st("t2.arm", 1'b0, 1'b1, 2'd0);
        cyc(32'h2, 1'b1);
        st("t2.early", 1'b0, 1'b1, 2'd0);
        cyc(32'h1, 1'b1);
        st("t2.lvl1", 1'b0, 1'b1, 2'd1);
        cyc(32'h2, 1'b1);
        st("t2.run", 1'b1, 1'b1, 2'd1);
        tick();
        st("t2.done", 1'b0, 1'b0, 2'd1);

        // delay counting ignores non-strobe cycles
        wr(2'd0, 32'hF, 32'h1, ST | 32'd3);
        arm();
        cyc(32'h1, 1'b1);
        st("t3.match", 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(32'h1, 1'b0);
            st("t3.nostb", 1'b0, 1'b1, 2'd0);
        end
        cyc(32'h0, 1'b1);
        st("t3.stb1", 1'b0, 1'b1, 2'd0);
        cyc(32'h0, 1'b1);
        st("t3.stb2", 1'b0, 1'b1, 2'd0);
        cyc(32'h0, 1'b1);
        st("t3.run", 1'b1, 1'b1, 2'd0);
        tick();
        st("t3.done", 1'b0, 1'b0, 2'd0);

        // lowest-index start stage wins
        wr(2'd0, 32'hF, 32'h1, 32'h0);
        wr(2'd1, 32'hF, 32'h7, ST | 32'd5);
        wr(2'd2, 32'hF, 32'h7, ST);
        arm();
        cyc(32'h7, 1'b1);
        st("t4.match", 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(32'h0, 1'b1);
            st("t4.wait", 1'b0, 1'b1, 2'd0);
        end
        cyc(32'h0, 1'b1);
        st("t4.run", 1'b1, 1'b1, 2'd0);
        tick();
        st("t4.done", 1'b0, 1'b0, 2'd0);

        // re-arm during DELAY at counter 2
        arm();
        cyc(32'h1, 1'b1);
        st("t5.lvl1", 1'b0, 1'b1, 2'd1);
        cyc(32'h7, 1'b1);
        for (int i = 0; i < 3; i++) cyc(32'h0, 1'b1);
        st("t5.cnt2", 1'b0, 1'b1, 2'd1);
        arm();
        st("t5.rearm", 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(32'h0, 1'b1);
            st("t5.armed", 1'b0, 1'b1, 2'd0);
        end
        cyc(32'h7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(32'h0, 1'b1);
            st("t5.wait", 1'b0, 1'b1, 2'd0);
        end
        cyc(32'h0, 1'b1);
        st("t5.run", 1'b1, 1'b1, 2'd0);
        tick();
        st("t5.done", 1'b0, 1'b0, 2'd0);

        // asynchronous reset mid-DELAY
        arm();
        cyc(32'h1, 1'b1);
        cyc(32'h7, 1'b1);
        st("t6.delay", 1'b0, 1'b1, 2'd1);
        #2 rst_in = 1'b0;
        #1 st("t6.async", 1'b0, 1'b0, 2'd0);
        tick();
        tick();
        rst_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(32'h0, 1'b1);
            st("t6.quiet", 1'b0, 1'b0, 2'd0);
        end
        stg_i = 2'd0; cmd_i = ST; set_cfg_i = 1'b1;
        tick();
        set_cfg_i = 1'b0;
        arm();
        cyc(32'hDEAD_BEEF, 1'b1);
        st("t6.cleared", 1'b1, 1'b1, 2'd0);
        tick();
        st("t6.done", 1'b0, 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trigger.md
Name: trigger

Overview:
- Multi-stage trigger unit placed directly upstream of the main capture FSM.
- Compares each strobed sample against per-stage mask/value pairs and advances a trigger level when a stage matches.
- A match on a stage flagged "start" waits a programmable number of further samples, then emits the single-cycle run pulse that drives the capture FSM's run input.
- Configuration arrives as 32-bit command words from the command decoder.

Parameters:
- WIDTH, 32, sample and command word width.
- STAGES, 4, number of trigger stages (fixed at 4; stage select is 2 bits).

Ports:
- clk_i  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- cmd_i  in  WIDTH  command payload
- stg_i  in  2  stage index for config writes
- set_mask_i  in  1  write cmd_i to mask[stg_i]
- set_val_i  in  1  write cmd_i to value[stg_i]
- set_cfg_i  in  1  write cmd_i to cfg[stg_i]
- arm_i  in  1  arm trigger; clears level
- data_i  in  WIDTH  current sample
- stb_i  in  1  data_i valid this cycle
- armed_o  out  1  high while in ARMED or DELAY
- lvl_o  out  2  current trigger level
- run_o  out  1  single-cycle pulse to capture FSM

Behaviour:
- Reset (asynchronous, active-low):
  - all mask, value and cfg registers cleared to 0; state IDLE; level 0; delay counter 0.
  - run_o=0, armed_o=0, lvl_o=0.
- Config register writes:
  - Take effect on the clock edge in any state.
  - If several set_* strobes are asserted in one cycle, all addressed registers are written.
- cfg word fields: [15:0] delay, [17:16] stage level, [27] start. Other bits are ignored.
- Stage s matches when both hold:
  - ((data_i ^ value[s]) & mask[s]) == 0, and
  - cfg[s].level <= current level.
  - A stage with mask 0 matches on every strobe once its level is reached.
- States:
  - IDLE: no evaluation. arm_i -> ARMED, level=0.
  - ARMED: evaluated only in cycles with stb_i=1. Outcomes:
    - At least one matching stage has start=1: the lowest-index such stage wins; delay counter loads its delay; -> DELAY. Level is unchanged.
    - Otherwise, at least one stage matches: level = min(level+1, 3). Only one increment per sample, regardless of how many stages match.
    - No match: no change.
  - DELAY:
    - Delay counter = 0: run_o=1 for this cycle only (Moore output), then -> IDLE.
    - Counter != 0 and stb_i=1: decrement.
    - Samples without stb_i do not count.
- Latency:
  - delay=0: run_o is high exactly one clock after the matching stb_i cycle.
  - delay=N: run_o is high one clock after the cycle in which the Nth subsequent stb_i decrements the counter to 0.
- arm_i in ARMED or DELAY: restarts the trigger. Level=0, any pending delay is cancelled, state -> ARMED. No run_o is produced that cycle.
- arm_i takes priority over match evaluation in the same cycle.
- armed_o = (state != IDLE).
- After run_o the block stays IDLE until the next arm_i. No automatic re-arm.
- Asynchronous reset at any point, including during DELAY, returns to IDLE immediately; a pending run_o is never emitted.
- Delay counter is 16 bits. There is no wrap, because it only decrements from the loaded value down to 0.

Test Plan:
- Reset with cfg stage0 = {start=1, delay=0}, mask0=0xFF, value0=0x5A; arm; apply stb with data 0x12, then 0x5A -> run_o pulses one clock after the 0x5A strobe, for one cycle; armed_o drops in the same edge.
- Two-level sequence:
  - Configure stage0: mask=0xF, value=0x1, level=0, start=0.
  - Configure stage1: mask=0xF, value=0x2, level=1, start=1.
  - Send 0x2 -> no run.
  - Send 0x1 -> lvl_o becomes 1.
  - Send 0x2 -> run_o pulses.
- Delay counting: start stage with delay=3; match, then 5 idle cycles with stb_i=0, then 3 strobes -> run_o high exactly one clock after the third post-match strobe, never earlier.
- Priority: stages 1 and 2 both start=1, delays 5 and 0, both matching the same sample -> stage 1's delay (5 strobes) is used; run_o appears only after 5 strobes.
- Re-arm during DELAY at counter=2 -> state ARMED, lvl_o=0, no run_o; a later match restarts the delay from the full value.
- Assert rst_in=0 asynchronously mid-DELAY, between clock edges -> run_o, armed_o and lvl_o go to 0 immediately; no pulse after release; all config registers read back as zero (a mask-0 start stage now fires on the first strobe after arm).
